// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// One transaction in flight at a time; data wins ties unless it won the previous grant.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  logic       last_d;
  logic       drop;
  logic       is_fetch;
  logic       is_store;
  logic [2:0] cnt;
  logic       d_req;
  logic       pick_d;

  assign d_req  = d_re | d_we;
  assign pick_d = d_req && (!if_req || !last_d);
  assign d_gnt  = (state == IDLE) && !rst && pick_d;
  assign if_gnt = (state == IDLE) && !rst && if_req && !pick_d;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      drop      <= 1'b0;
      is_fetch  <= 1'b0;
      is_store  <= 1'b0;
      cnt       <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // memory command and valid strobes are single-cycle pulses
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (d_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_we ? d_wdata : '0;
            last_d    <= 1'b1;
            is_fetch  <= 1'b0;
            is_store  <= d_we;
            state     <= ISSUE;
          end else if (if_gnt) begin
            mem_en    <= 1'b1;
            mem_addr  <= if_addr;
            last_d    <= 1'b0;
            is_fetch  <= 1'b1;
            is_store  <= 1'b0;
            drop      <= flush;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_fetch && flush) drop <= 1'b1;
          if (is_store) begin
            d_valid <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt   <= 3'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (is_fetch && flush) drop <= 1'b1;
          if (cnt == 3'd0) begin
            state <= IDLE;
            if (is_fetch) begin
              // a flush in the sampling cycle itself must also suppress the result
              if (!(drop || flush)) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
              end
            end else begin
              d_valid <= 1'b1;
              d_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        flush;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .flush(flush),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data present only in the cycle MEM_LAT=2 after mem_en, garbage otherwise
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0;
  always @(posedge clk) begin
    v0 <= mem_en && !mem_we;
    a0 <= mem_addr;
    v1 <= v0;
    a1 <= a0;
  end
  assign mem_rdata = v1 ? data_of(a1) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic nck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      nc();
      #1;
      chk(tag, {31'b0, if_gnt | d_gnt | if_valid | d_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; flush = 1'b0;
    d_re = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // 1: reset holds everything at zero despite pending requests
    for (int i = 0; i < 2; i++) begin
      nc(); #1;
      chk("rst_gnt",   {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("rst_valid", {30'b0, if_valid, d_valid}, 32'd0);
      chk("rst_mem",   {30'b0, mem_en, mem_we}, 32'd0);
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      chk("rst_ifrd",  if_rdata, 32'd0);
      chk("rst_drd",   d_rdata, 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
    end
    rst = 1'b0; if_req = 1'b0; d_re = 1'b0;
    nc();

    // 2: single fetch
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk("f_gnt", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0; #1;
    chk("f_men", {31'b0, mem_en}, 32'd1);
    chk("f_maddr", mem_addr, 32'h100);
    chk("f_mwe", {31'b0, mem_we}, 32'd0);
    chk("f_busy1", {31'b0, busy}, 32'd1);
    nc(); #1;
    chk("f_men_g2", {31'b0, mem_en}, 32'd0);
    chk("f_busy2", {31'b0, busy}, 32'd1);
    nc(); #1;
    chk("f_busy3", {31'b0, busy}, 32'd1);
    chk("f_noval3", {31'b0, if_valid}, 32'd0);
    nc(); #1;
    chk("f_val", {31'b0, if_valid}, 32'd1);
    chk("f_rdata", if_rdata, 32'h00500093);
    chk("f_busy4", {31'b0, busy}, 32'd0);

    // 3: contention, data first then strict alternation
    nc();
    if_req = 1'b1; if_addr = 32'h200; d_re = 1'b1; d_addr = 32'h40; #1;
    chk("a_dgnt", {31'b0, d_gnt}, 32'd1);
    chk("a_ifgnt", {31'b0, if_gnt}, 32'd0);
    nc(); d_re = 1'b0; #1;
    chk("a_maddr", mem_addr, 32'h40);
    nck(2, "a_quiet");
    nc(); #1;
    chk("a_dval", {31'b0, d_valid}, 32'd1);
    chk("a_drd", d_rdata, data_of(32'h40));
    chk("a_ifgnt2", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0; #1;
    chk("a_maddr2", mem_addr, 32'h200);
    nc(); nc(); nc(); #1;
    chk("a_ifval", {31'b0, if_valid}, 32'd1);
    chk("a_ifrd", if_rdata, data_of(32'h200));
    if_req = 1'b1; if_addr = 32'h204; d_re = 1'b1; d_addr = 32'h44; #1;
    chk("a_dgnt3", {31'b0, d_gnt}, 32'd1);
    chk("a_ifgnt3", {31'b0, if_gnt}, 32'd0);
    nc(); d_re = 1'b0;
    nc(); nc(); nc(); #1;
    chk("a_dval2", {31'b0, d_valid}, 32'd1);
    chk("a_drd2", d_rdata, data_of(32'h44));
    chk("a_ifgnt4", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0;
    nc(); nc(); nc(); #1;
    chk("a_ifval2", {31'b0, if_valid}, 32'd1);
    chk("a_ifrd2", if_rdata, data_of(32'h204));

    // 4: store, then simultaneous re+we treated as store
    nc();
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; #1;
    chk("s_gnt", {31'b0, d_gnt}, 32'd1);
    nc(); d_we = 1'b0; #1;
    chk("s_men", {30'b0, mem_en, mem_we}, 32'd3);
    chk("s_maddr", mem_addr, 32'h20);
    chk("s_mwd", mem_wdata, 32'hDEADBEEF);
    nc(); #1;
    chk("s_dval", {31'b0, d_valid}, 32'd1);
    chk("s_drd", d_rdata, data_of(32'h44));
    chk("s_busy", {31'b0, busy}, 32'd0);
    d_re = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h12345678; #1;
    chk("rw_gnt", {31'b0, d_gnt}, 32'd1);
    nc(); d_re = 1'b0; d_we = 1'b0; #1;
    chk("rw_mwe", {30'b0, mem_en, mem_we}, 32'd3);
    chk("rw_mwd", mem_wdata, 32'h12345678);
    nc(); #1;
    chk("rw_dval", {31'b0, d_valid}, 32'd1);
    chk("rw_drd", d_rdata, data_of(32'h44));

    // 5: flush drops an in-flight fetch, next fetch is normal
    nc();
    if_req = 1'b1; if_addr = 32'h300; #1;
    chk("fl_gnt", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0;
    nc(); flush = 1'b1;
    nc(); flush = 1'b0;
    nc(); #1;
    chk("fl_noval", {31'b0, if_valid}, 32'd0);
    chk("fl_ifrd", if_rdata, data_of(32'h204));
    chk("fl_busy", {31'b0, busy}, 32'd0);
    if_req = 1'b1; if_addr = 32'h304; #1;
    chk("fl_gnt2", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0;
    nc(); nc(); nc(); #1;
    chk("fl_val2", {31'b0, if_valid}, 32'd1);
    chk("fl_ifrd2", if_rdata, data_of(32'h304));

    // 6: reset mid-fetch abandons it
    nc();
    if_req = 1'b1; if_addr = 32'h400; #1;
    chk("r_gnt", {31'b0, if_gnt}, 32'd1);
    nc(); if_req = 1'b0; #1;
    chk("r_men", {31'b0, mem_en}, 32'd1);
    nc(); rst = 1'b1;
    nc(); rst = 1'b0; #1;
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_men2", {31'b0, mem_en}, 32'd0);
    chk("r_ifrd", if_rdata, 32'd0);
    chk("r_drd", d_rdata, 32'd0);
    chk("r_val", {31'b0, if_valid}, 32'd0);
    nck(3, "r_quiet");
    chk("r_ifrd_end", if_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
